// File: rtl/cpu_defs.sv
// cpu_defs: shared encodings for the CR16-style multi-cycle controller.
// Holds the FSM state encoding, ALU/PC/write-back select codes, opcode and
// function-field constants, and the EXEC control bundle type.
package cpu_defs;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StMulw   = 3'd4
    } state_e;

    // ALU operation select
    localparam logic [3:0] AluAdd = 4'd0;
    localparam logic [3:0] AluSub = 4'd1;
    localparam logic [3:0] AluAnd = 4'd2;
    localparam logic [3:0] AluOr  = 4'd3;
    localparam logic [3:0] AluXor = 4'd4;
    localparam logic [3:0] AluNot = 4'd5;
    localparam logic [3:0] AluLsh = 4'd6;
    localparam logic [3:0] AluAsh = 4'd7;
    localparam logic [3:0] AluMul = 4'd8;

    // PC update mode
    localparam logic [1:0] PcNext   = 2'b00;
    localparam logic [1:0] PcOffset = 2'b01;
    localparam logic [1:0] PcAbs    = 2'b10;

    // Register-file write-back source
    localparam logic [1:0] WbAlu  = 2'b00;
    localparam logic [1:0] WbMem  = 2'b01;
    localparam logic [1:0] WbRsrc = 2'b10;
    localparam logic [1:0] WbImm  = 2'b11;

    // Immediate extension mode
    localparam logic [1:0] ExtSign = 2'b00;
    localparam logic [1:0] ExtZero = 2'b01;

    // Major opcodes (instr[15:12])
    localparam logic [3:0] OpRType = 4'b0000;
    localparam logic [3:0] OpLdSt  = 4'b0100;
    localparam logic [3:0] OpShift = 4'b1000;
    localparam logic [3:0] OpBcond = 4'b1100;
    localparam logic [3:0] OpAndi  = 4'b0001;
    localparam logic [3:0] OpOri   = 4'b0010;
    localparam logic [3:0] OpXori  = 4'b0011;
    localparam logic [3:0] OpAddi  = 4'b0101;
    localparam logic [3:0] OpSubi  = 4'b1001;
    localparam logic [3:0] OpCmpi  = 4'b1011;
    localparam logic [3:0] OpMovi  = 4'b1101;
    localparam logic [3:0] OpMuli  = 4'b1110;

    // ALU function codes; R-type carries them in instr[7:4], and each
    // immediate form reuses the same value as its major opcode.
    localparam logic [3:0] FnAnd = 4'b0001;
    localparam logic [3:0] FnOr  = 4'b0010;
    localparam logic [3:0] FnXor = 4'b0011;
    localparam logic [3:0] FnAdd = 4'b0101;
    localparam logic [3:0] FnSub = 4'b1001;
    localparam logic [3:0] FnCmp = 4'b1011;
    localparam logic [3:0] FnMov = 4'b1101;
    localparam logic [3:0] FnMul = 4'b1110;

    // Shift and load/store/jump sub-functions (instr[7:4])
    localparam logic [3:0] ExtLsh   = 4'b0100;
    localparam logic [3:0] ExtAsh   = 4'b0001;
    localparam logic [3:0] ExtLoad  = 4'b0000;
    localparam logic [3:0] ExtStor  = 4'b0100;
    localparam logic [3:0] ExtJcond = 4'b1100;

    // Controls the FSM drives during EXEC (and reuses in other states)
    typedef struct packed {
        logic       wr_en;
        logic [3:0] alu_sel;
        logic       alu_src;
        logic [1:0] wb_sel;
        logic       pc_en;
        logic [1:0] pc_mode;
        logic [1:0] sext;
        logic       cmp_f_en;
        logic       of_f_en;
        logic       z_f_en;
        logic       mem_wr_en;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational map from (opcode, opcode_ext, cmp_result) to
// the EXEC-cycle control bundle. Undefined encodings yield an all-zero NOP.
// Macro CTRL_MUL_EN: when defined, MUL/MULI decode and is_mul_o is present.
module instr_decoder
    import cpu_defs::*;
(
    input  logic [3:0] opcode_i,
    input  logic [3:0] opcode_ext_i,
    input  logic       cmp_result_i,
    output ctrl_t      ctrl_o,
    output logic       is_load_o
`ifdef CTRL_MUL_EN
    ,
    output logic       is_mul_o
`endif
);

    logic [3:0] fn;
    logic       imm;
    logic       alu_hit;

    // Decode the current instruction into its EXEC controls.
    always_comb begin
        ctrl_o    = '0;
        is_load_o = 1'b0;
`ifdef CTRL_MUL_EN
        is_mul_o  = 1'b0;
`endif
        imm     = (opcode_i != OpRType);
        // Immediate forms use the opcode itself as the function code.
        fn      = imm ? opcode_i : opcode_ext_i;
        alu_hit = 1'b0;

        unique case (opcode_i)
            OpRType, OpAndi, OpOri, OpXori, OpAddi, OpSubi, OpCmpi, OpMovi, OpMuli: begin
                alu_hit = 1'b1;
                case (fn)
                    FnAdd: begin
                        ctrl_o.alu_sel = AluAdd;
                        ctrl_o.wr_en   = 1'b1;
                        ctrl_o.of_f_en = 1'b1;
                        ctrl_o.z_f_en  = 1'b1;
                    end
                    FnSub: begin
                        ctrl_o.alu_sel = AluSub;
                        ctrl_o.wr_en   = 1'b1;
                        ctrl_o.of_f_en = 1'b1;
                        ctrl_o.z_f_en  = 1'b1;
                    end
                    FnAnd, FnOr, FnXor: begin
                        ctrl_o.alu_sel = (fn == FnAnd) ? AluAnd :
                                         (fn == FnOr)  ? AluOr  : AluXor;
                        ctrl_o.wr_en   = 1'b1;
                        ctrl_o.z_f_en  = 1'b1;
                        ctrl_o.sext    = imm ? ExtZero : ExtSign;
                    end
                    FnCmp: begin
                        ctrl_o.alu_sel  = AluSub;
                        ctrl_o.cmp_f_en = 1'b1;
                        ctrl_o.z_f_en   = 1'b1;
                    end
                    FnMov: begin
                        ctrl_o.wr_en  = 1'b1;
                        ctrl_o.wb_sel = imm ? WbImm : WbRsrc;
                    end
`ifdef CTRL_MUL_EN
                    FnMul: begin
                        ctrl_o.alu_sel = AluMul;
                        is_mul_o       = 1'b1;
                    end
`endif
                    default: alu_hit = 1'b0;
                endcase
                ctrl_o.alu_src = alu_hit & imm;
            end
            OpShift: begin
                if (opcode_ext_i == ExtLsh) begin
                    ctrl_o.alu_sel = AluLsh;
                    ctrl_o.wr_en   = 1'b1;
                end else if (opcode_ext_i == ExtAsh) begin
                    ctrl_o.alu_sel = AluAsh;
                    ctrl_o.wr_en   = 1'b1;
                end
            end
            OpLdSt: begin
                if (opcode_ext_i == ExtLoad) begin
                    is_load_o = 1'b1;
                end else if (opcode_ext_i == ExtStor) begin
                    ctrl_o.mem_wr_en = 1'b1;
                end else if (opcode_ext_i == ExtJcond && cmp_result_i) begin
                    ctrl_o.pc_en   = 1'b1;
                    ctrl_o.pc_mode = PcAbs;
                end
            end
            OpBcond: begin
                // Offset applies to the PC already incremented in DECODE.
                if (cmp_result_i) begin
                    ctrl_o.pc_en   = 1'b1;
                    ctrl_o.pc_mode = PcOffset;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle FETCH/DECODE/EXEC/MEM(/MULW) control FSM for the
// 16-bit CR16-style DataPath. Outputs are combinational from the registered
// state (plus cmp_result for branches) and are forced to 0 while reset is high.
// Macro CTRL_MUL_EN: when defined, MUL/MULI run MUL_CYCLES extra MULW cycles.
module cpu_controller
    import cpu_defs::*;
#(
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [3:0] opcode_ext,
    input  logic       cmp_result,
    output logic       wr_en,
    output logic [3:0] alu_sel,
    output logic       alu_src,
    output logic [1:0] write_back_sel,
    output logic       pc_en,
    output logic [1:0] pc_addr_mode,
    output logic       next_instr,
    output logic       instr_en,
    output logic [1:0] sign_ext_mode,
    output logic       cmp_f_en,
    output logic       of_f_en,
    output logic       z_f_en,
    output logic       mem_wr_en,
    output logic [2:0] state
);

    if (MUL_CYCLES < 1 || MUL_CYCLES > 4) begin : g_bad_mul_cycles
        $error("MUL_CYCLES must be in 1..4");
    end

    state_e state_q, state_d;
    ctrl_t  dec;
    ctrl_t  ctrl;
    logic   dec_is_load;
    logic   next_instr_c;
    logic   instr_en_c;

`ifdef CTRL_MUL_EN
    localparam logic [1:0] MulLast = 2'(MUL_CYCLES - 1);
    logic       dec_is_mul;
    logic [1:0] mul_cnt_q, mul_cnt_d;
`endif

    instr_decoder u_decoder (
        .opcode_i     (opcode),
        .opcode_ext_i (opcode_ext),
        .cmp_result_i (cmp_result),
        .ctrl_o       (dec),
        .is_load_o    (dec_is_load)
`ifdef CTRL_MUL_EN
        ,
        .is_mul_o     (dec_is_mul)
`endif
    );

    // Next-state and control outputs for the current state.
    always_comb begin
        state_d      = state_q;
        ctrl         = '0;
        next_instr_c = 1'b0;
        instr_en_c   = 1'b0;
`ifdef CTRL_MUL_EN
        mul_cnt_d    = mul_cnt_q;
`endif
        unique case (state_q)
            StFetch: begin
                next_instr_c = 1'b1;
                state_d      = StDecode;
            end
            StDecode: begin
                next_instr_c = 1'b1;
                instr_en_c   = 1'b1;
                ctrl.pc_en   = 1'b1;
                ctrl.pc_mode = PcNext;
                state_d      = StExec;
            end
            StExec: begin
                ctrl = dec;
                if (dec_is_load) begin
                    state_d = StMem;
`ifdef CTRL_MUL_EN
                end else if (dec_is_mul) begin
                    state_d   = StMulw;
                    mul_cnt_d = '0;
`endif
                end else begin
                    state_d = StFetch;
                end
            end
            StMem: begin
                ctrl.wr_en  = 1'b1;
                ctrl.wb_sel = WbMem;
                state_d     = StFetch;
            end
            StMulw: begin
`ifdef CTRL_MUL_EN
                ctrl.alu_sel = AluMul;
                ctrl.alu_src = dec.alu_src;
                if (mul_cnt_q == MulLast) begin
                    ctrl.wr_en  = 1'b1;
                    ctrl.wb_sel = WbAlu;
                    ctrl.z_f_en = 1'b1;
                    state_d     = StFetch;
                end else begin
                    mul_cnt_d = mul_cnt_q + 2'd1;
                end
`else
                state_d = StFetch;
`endif
            end
            default: state_d = StFetch;
        endcase

        // Reset aborts the instruction in the same cycle: no partial writes.
        if (reset) begin
            ctrl         = '0;
            next_instr_c = 1'b0;
            instr_en_c   = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CTRL_MUL_EN
    // MULW cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_cnt_q <= '0;
        end else begin
            mul_cnt_q <= mul_cnt_d;
        end
    end
`endif

    assign wr_en          = ctrl.wr_en;
    assign alu_sel        = ctrl.alu_sel;
    assign alu_src        = ctrl.alu_src;
    assign write_back_sel = ctrl.wb_sel;
    assign pc_en          = ctrl.pc_en;
    assign pc_addr_mode   = ctrl.pc_mode;
    assign next_instr     = next_instr_c;
    assign instr_en       = instr_en_c;
    assign sign_ext_mode  = ctrl.sext;
    assign cmp_f_en       = ctrl.cmp_f_en;
    assign of_f_en        = ctrl.of_f_en;
    assign z_f_en         = ctrl.z_f_en;
    assign mem_wr_en      = ctrl.mem_wr_en;
    assign state          = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed and randomized checks of cpu_controller against
// an instruction-level model (instruction kind + cycle index within it).
`timescale 1ns/1ps
module tb_cpu_controller;

    localparam int MUL_CYCLES = 2;
`ifdef CTRL_MUL_EN
    localparam bit MulOn = 1'b1;
`else
    localparam bit MulOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode, opcode_ext;
    logic       cmp_result;
    logic       wr_en, alu_src, pc_en, next_instr, instr_en;
    logic       cmp_f_en, of_f_en, z_f_en, mem_wr_en;
    logic [3:0] alu_sel;
    logic [1:0] write_back_sel, pc_addr_mode, sign_ext_mode;
    logic [2:0] state;

    cpu_controller #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk            (clk),
        .reset          (reset),
        .opcode         (opcode),
        .opcode_ext     (opcode_ext),
        .cmp_result     (cmp_result),
        .wr_en          (wr_en),
        .alu_sel        (alu_sel),
        .alu_src        (alu_src),
        .write_back_sel (write_back_sel),
        .pc_en          (pc_en),
        .pc_addr_mode   (pc_addr_mode),
        .next_instr     (next_instr),
        .instr_en       (instr_en),
        .sign_ext_mode  (sign_ext_mode),
        .cmp_f_en       (cmp_f_en),
        .of_f_en        (of_f_en),
        .z_f_en         (z_f_en),
        .mem_wr_en      (mem_wr_en),
        .state          (state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int phase = 0;        // cycle index within the current instruction
    bit auto_mode = 1'b0; // random instruction/cmp_result selection

    typedef enum int {KNop, KAdd, KSub, KAnd, KOr, KXor, KCmp, KMov, KMul,
                      KLsh, KAsh, KLoad, KStor, KJmp, KBr} kind_e;

    function automatic kind_e kind_of(logic [3:0] op, logic [3:0] ext);
        logic [3:0] f;
        if (op == 4'h4) return (ext == 4'h0) ? KLoad : (ext == 4'h4) ? KStor :
                               (ext == 4'hC) ? KJmp : KNop;
        if (op == 4'h8) return (ext == 4'h4) ? KLsh : (ext == 4'h1) ? KAsh : KNop;
        if (op == 4'hC) return KBr;
        if (!(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hE})) return KNop;
        f = (op == 4'h0) ? ext : op;
        case (f)
            4'h5: return KAdd;
            4'h9: return KSub;
            4'h1: return KAnd;
            4'h2: return KOr;
            4'h3: return KXor;
            4'hB: return KCmp;
            4'hD: return KMov;
            4'hE: return MulOn ? KMul : KNop;
            default: return KNop;
        endcase
    endfunction

    function automatic int len_of(kind_e k);
        if (k == KLoad) return 4;
        if (k == KMul) return 3 + MUL_CYCLES;
        return 3;
    endfunction

    // Expected outputs, packed as {state, wr, alu, src, wb, pc, pm, ni, ie, se, cf, of, zf, mw}.
    function automatic logic [21:0] model_out(int ph, logic [3:0] op, logic [3:0] ext,
                                              logic c, logic rst);
        logic [2:0] st;
        logic [3:0] alu;
        logic [1:0] wb, pm, se;
        logic       wr, src, pc, ni, ie, cf, of, zf, mw, imm;
        kind_e      k;
        k = kind_of(op, ext);
        imm = (op != 4'h0);
        st = 3'd0; alu = 4'd0; wb = 2'd0; pm = 2'd0; se = 2'd0;
        wr = 0; src = 0; pc = 0; ni = 0; ie = 0; cf = 0; of = 0; zf = 0; mw = 0;
        if (!rst) begin
            if (ph == 0) begin
                ni = 1;
            end else if (ph == 1) begin
                st = 3'd1; ni = 1; ie = 1; pc = 1;
            end else if (ph == 2) begin
                st = 3'd2;
                case (k)
                    KAdd: begin alu = 4'd0; wr = 1; of = 1; zf = 1; src = imm; end
                    KSub: begin alu = 4'd1; wr = 1; of = 1; zf = 1; src = imm; end
                    KAnd: begin alu = 4'd2; wr = 1; zf = 1; src = imm; se = imm ? 2'd1 : 2'd0; end
                    KOr:  begin alu = 4'd3; wr = 1; zf = 1; src = imm; se = imm ? 2'd1 : 2'd0; end
                    KXor: begin alu = 4'd4; wr = 1; zf = 1; src = imm; se = imm ? 2'd1 : 2'd0; end
                    KCmp: begin alu = 4'd1; cf = 1; zf = 1; src = imm; end
                    KMov: begin wr = 1; wb = imm ? 2'd3 : 2'd2; src = imm; end
                    KMul: begin alu = 4'd8; src = imm; end
                    KLsh: begin alu = 4'd6; wr = 1; end
                    KAsh: begin alu = 4'd7; wr = 1; end
                    KStor: mw = 1;
                    KJmp: if (c) begin pc = 1; pm = 2'd2; end
                    KBr:  if (c) begin pc = 1; pm = 2'd1; end
                    default: ;
                endcase
            end else if (k == KLoad) begin
                st = 3'd3; wr = 1; wb = 2'd1;
            end else begin
                st = 3'd4; alu = 4'd8; src = imm;
                if (ph == 2 + MUL_CYCLES) begin wr = 1; zf = 1; end
            end
        end
        return {st, wr, alu, src, wb, pc, pm, ni, ie, se, cf, of, zf, mw};
    endfunction

    function automatic logic [21:0] pack_dut();
        return {state, wr_en, alu_sel, alu_src, write_back_sel, pc_en, pc_addr_mode,
                next_instr, instr_en, sign_ext_mode, cmp_f_en, of_f_en, z_f_en, mem_wr_en};
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [21:0] exp_v, got_v;
        exp_v = model_out(phase, opcode, opcode_ext, cmp_result, reset);
        got_v = pack_dut();
        n_cmp++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL model t=%0t ph=%0d op=%h ext=%h cmp=%b rst=%b: got %b expected %b",
                     $time, phase, opcode, opcode_ext, cmp_result, reset, got_v, exp_v);
        end
    end

    task automatic pick_instr();
        logic [3:0] ext_tab [11];
        ext_tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE};
        opcode = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0) opcode_ext = ext_tab[$urandom_range(0, 10)];
        else opcode_ext = 4'($urandom_range(0, 15));
    endtask

    // One clock: advance the model in step with the DUT, then update inputs.
    task automatic cycle();
        logic rst_at_edge;
        @(posedge clk);
        rst_at_edge = reset;
        #1;
        if (rst_at_edge) begin
            phase = 0;
        end else begin
            phase++;
            if (phase >= len_of(kind_of(opcode, opcode_ext))) begin
                phase = 0;
                if (auto_mode) pick_instr();
            end
        end
        if (auto_mode) cmp_result = 1'($urandom_range(0, 1));
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 4'h0; opcode_ext = 4'h5; cmp_result = 1'b0;
        #2;
        chk("reset_state", 32'(state), 0);
        chk("reset_next_instr", 32'(next_instr), 0);
        chk("reset_instr_en", 32'(instr_en), 0);

        // ADD R-type
        cycle();
        reset = 1'b0;
        #1;
        chk("add_fetch_state", 32'(state), 0);
        chk("add_fetch_next_instr", 32'(next_instr), 1);
        cycle();
        chk("add_decode_state", 32'(state), 1);
        chk("add_decode_instr_en", 32'(instr_en), 1);
        chk("add_decode_pc_en", 32'(pc_en), 1);
        chk("add_decode_pc_mode", 32'(pc_addr_mode), 0);
        cycle();
        chk("add_exec_state", 32'(state), 2);
        chk("add_exec_wr_en", 32'(wr_en), 1);
        chk("add_exec_alu_sel", 32'(alu_sel), 0);
        chk("add_exec_alu_src", 32'(alu_src), 0);
        chk("add_exec_flags", 32'({of_f_en, z_f_en, cmp_f_en}), 32'b110);
        cycle();
        chk("add_done_state", 32'(state), 0);

        // LOAD
        opcode = 4'h4; opcode_ext = 4'h0;
        cycle(); cycle();
        chk("load_exec_state", 32'(state), 2);
        chk("load_exec_next_instr", 32'(next_instr), 0);
        chk("load_exec_wr_en", 32'(wr_en), 0);
        cycle();
        chk("load_mem_state", 32'(state), 3);
        chk("load_mem_wr", 32'({wr_en, write_back_sel}), 32'b101);
        cycle();
        chk("load_done_state", 32'(state), 0);

        // STOR
        opcode = 4'h4; opcode_ext = 4'h4;
        cycle(); cycle();
        chk("stor_exec_mem_wr_en", 32'(mem_wr_en), 1);
        chk("stor_exec_wr_en", 32'(wr_en), 0);
        cycle();
        chk("stor_after_mem_wr_en", 32'(mem_wr_en), 0);
        chk("stor_done_state", 32'(state), 0);

        // Bcond taken and not taken
        opcode = 4'hC; opcode_ext = 4'h0; cmp_result = 1'b1;
        cycle(); cycle();
        chk("bcond_taken", 32'({pc_en, pc_addr_mode}), 32'b101);
        cmp_result = 1'b0;
        #1;
        chk("bcond_not_taken_pc_en", 32'(pc_en), 0);
        cycle();

        // Undefined opcode 0xF runs as NOP
        opcode = 4'hF; opcode_ext = 4'h5;
        cycle(); cycle();
        chk("undef_exec_state", 32'(state), 2);
        chk("undef_exec_outputs", 32'(pack_dut() & 22'h07FFFF), 0);
        cycle();
        chk("undef_done_state", 32'(state), 0);

        // MUL R-type
        opcode = 4'h0; opcode_ext = 4'hE;
        cycle(); cycle();
        chk("mul_exec_wr_en", 32'(wr_en), 0);
        cycle();
`ifdef CTRL_MUL_EN
        chk("mul_w1_state", 32'(state), 4);
        chk("mul_w1_wr_en", 32'(wr_en), 0);
        cycle();
        chk("mul_w2_state", 32'(state), 4);
        chk("mul_w2_wr", 32'({wr_en, alu_sel}), 32'h18);
        cycle();
`endif
        chk("mul_done_state", 32'(state), 0);

        // Reset during ADD EXEC
        opcode = 4'h0; opcode_ext = 4'h5;
        cycle(); cycle();
        chk("abort_pre_wr_en", 32'(wr_en), 1);
        reset = 1'b1;
        phase = 0;
        #1;
        chk("abort_state", 32'(state), 0);
        chk("abort_wr_en", 32'(wr_en), 0);
        chk("abort_z_f_en", 32'(z_f_en), 0);
        cycle();
        reset = 1'b0;
        #1;
        chk("abort_restart_next_instr", 32'(next_instr), 1);

        // Randomized instruction stream with occasional mid-instruction reset
        auto_mode = 1'b1;
        repeat (4000) begin
            cycle();
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                phase = 0;
                cycle();
                reset = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
